// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with a 2-entry skid buffer and flush-to-bubble.
// Optional statistics counters are enabled by defining PIPE_STATS_EN.
module pipe_stage_buf #(
  parameter int unsigned          DATA_W     = 64,
  parameter logic [DATA_W-1:0]    BUBBLE_VAL = '0,
  parameter int unsigned          CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept, issue;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_valid_q ? main_q : BUBBLE_VAL;
  assign accept    = in_valid & in_ready;
  assign issue     = main_valid_q & out_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // The skid entry is younger than main, so it only ever moves into main.
      if (issue) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (accept && issue) begin
        main_d = in_data;
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_d       = in_data;
      end else if (issue) begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_d       = in_data;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // NOTE: payload registers are deliberately not reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

`ifdef PIPE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Counters saturate at all-ones and are cleared by reset only, never by flush.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (!main_valid_q && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: stimulus pushes expected payloads,
// an independent monitor pops and compares whenever an entry issues.
module tb_pipe_stage_buf;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] sb[$];

  pipe_stage_buf #(.DATA_W(DATA_W), .BUBBLE_VAL('0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; in_ready is compared against the hand-derived value.
  task automatic drive(input logic v, input logic [63:0] d, input logic ordy,
                       input logic fl, input logic rs, input logic exp_rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    if (!rs) check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (rs || fl) sb.delete();
    else if (v && exp_rdy) sb.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && !flush) begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("issue_unexpected", out_data, 64'hDEAD_BEEF);
          end else begin
            check("issue_data", out_data, sb.pop_front());
          end
        end else if (out_valid === 1'b0) begin
          check("bubble_data", out_data, 64'h0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    check("rst_bubble_cnt", 64'(bubble_cnt), 64'h0);

    // Flow: one entry per cycle, one cycle latency, no gaps.
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) check("flow_valid", 64'(out_valid), 64'h1);
      drive(1'b1, 64'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    check("flow_last_valid", 64'(out_valid), 64'h1);
    check("flow_last_data", out_data, 64'h5);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("flow_drained", 64'(out_valid), 64'h0);

    // Stall into the skid slot, then drain in order.
    drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0,    1'b0, 1'b0, 1'b0, 1'b0);
    check("skid_hold_data", out_data, 64'hA);
    drive(1'b0, '0,    1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0,    1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0,    1'b1, 1'b0, 1'b0, 1'b1);
    check("skid_drained", 64'(out_valid), 64'h0);

    // Flush from the skid state with a same-cycle input that must be dropped.
    drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'hC, 1'b0, 1'b1, 1'b0, 1'b0);
    check("flush_out_valid", 64'(out_valid), 64'h0);
    check("flush_out_data", out_data, 64'h0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("flush_no_c", 64'(out_valid), 64'h0);

    // Statistics: one bubble, five stall cycles, then a flush that must not clear.
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef PIPE_STATS_EN
    check("stats_stall_sat", 64'(stall_cnt), 64'h3);
    check("stats_bubble", 64'(bubble_cnt), 64'h1);
`else
    check("stats_stall_off", 64'(stall_cnt), 64'h0);
    check("stats_bubble_off", 64'(bubble_cnt), 64'h0);
`endif
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef PIPE_STATS_EN
    check("stats_stall_after_flush", 64'(stall_cnt), 64'h3);
    check("stats_bubble_after_flush", 64'(bubble_cnt), 64'h2);
`else
    check("stats_stall_after_flush", 64'(stall_cnt), 64'h0);
    check("stats_bubble_after_flush", 64'(bubble_cnt), 64'h0);
`endif

    // Priority: reset together with flush and a valid input.
    drive(1'b1, 64'hD, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'hE, 1'b1, 1'b1, 1'b1, 1'b1);
    check("prio_out_valid", 64'(out_valid), 64'h0);
    check("prio_out_data", out_data, 64'h0);
    check("prio_in_ready", 64'(in_ready), 64'h1);
    check("prio_stall_cnt", 64'(stall_cnt), 64'h0);
    check("prio_bubble_cnt", 64'(bubble_cnt), 64'h0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("prio_no_issue", 64'(out_valid), 64'h0);

    check("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
